// File: rtl/aes_prng_ctrl.sv
// PRNG handshake initiator for the masked AES core: seeds prng_top, gates encryption starts on live randomness,
// forces a reseed every RESEED_PERIOD encryptions and flags starvation. Request accept is same-cycle; seed wins over request.
module aes_prng_ctrl #(
   parameter int RESEED_PERIOD = 1024,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [79:0]      seed_in,
   input  logic             seed_valid,
   output logic             seed_ready,
   input  logic             req_valid,
   output logic             req_ready,
   output logic             aes_valid_in,
   input  logic             aes_ready,
   input  logic             aes_cipher_valid,
   output logic [79:0]      prng_seed,
   output logic             prng_start_reseed,
   input  logic             prng_busy,
   input  logic             prng_out_valid,
   output logic             prng_out_ready,
   output logic             need_reseed,
   output logic             rnd_starve,
   output logic [CNT_W-1:0] enc_count
);

   typedef enum logic [2:0] {
      ST_NOSEED,
      ST_PULSE,
      ST_WAIT,
      ST_READY,
      ST_RUN
   } state_t;

   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(RESEED_PERIOD);

   state_t           state_q, state_d;
   logic [79:0]      prng_seed_q, prng_seed_d;
   logic [CNT_W-1:0] enc_count_q, enc_count_d;
   logic             rnd_starve_q, rnd_starve_d;
   logic [CNT_W-1:0] enc_count_inc;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_NOSEED;
         prng_seed_q  <= '0;
         enc_count_q  <= '0;
         rnd_starve_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prng_seed_q  <= prng_seed_d;
         enc_count_q  <= enc_count_d;
         rnd_starve_q <= rnd_starve_d;
      end
   end

   // Saturating increment; with a nonzero period the count never reaches the ceiling anyway.
   assign enc_count_inc = (enc_count_q == '1) ? enc_count_q : enc_count_q + CNT_W'(1);

   always_comb begin
      state_d           = state_q;
      prng_seed_d       = prng_seed_q;
      enc_count_d       = enc_count_q;
      rnd_starve_d      = rnd_starve_q;
      seed_ready        = 1'b0;
      req_ready         = 1'b0;
      aes_valid_in      = 1'b0;
      prng_out_ready    = 1'b0;
      prng_start_reseed = 1'b0;

      unique case (state_q)
         ST_NOSEED: begin
            seed_ready = 1'b1;
            if (seed_valid) begin
               prng_seed_d = seed_in;
               state_d     = ST_PULSE;
            end
         end
         ST_PULSE: begin
            prng_start_reseed = 1'b1;
            state_d           = ST_WAIT;
         end
         ST_WAIT: begin
            if (!prng_busy && prng_out_valid) begin
               enc_count_d  = '0;
               rnd_starve_d = 1'b0;
               state_d      = ST_READY;
            end
         end
         ST_READY: begin
            seed_ready = 1'b1;
            req_ready  = aes_ready & prng_out_valid & ~prng_busy & ~seed_valid;
            if (seed_valid) begin
               prng_seed_d = seed_in;
               state_d     = ST_PULSE;
            end else if (req_valid && req_ready) begin
               aes_valid_in   = 1'b1;
               prng_out_ready = 1'b1;
               state_d        = ST_RUN;
            end
         end
         ST_RUN: begin
            prng_out_ready = 1'b1;
            if (!prng_out_valid) begin
               rnd_starve_d = 1'b1;
            end
            if (aes_cipher_valid) begin
               enc_count_d = enc_count_inc;
               if (RESEED_PERIOD != 0 && enc_count_inc == PERIOD_C) begin
                  state_d = ST_NOSEED;
               end else begin
                  state_d = ST_READY;
               end
            end
         end
         default: state_d = ST_NOSEED;
      endcase
   end

   assign prng_seed   = prng_seed_q;
   assign enc_count   = enc_count_q;
   assign rnd_starve  = rnd_starve_q;
   assign need_reseed = (state_q == ST_NOSEED);

endmodule

// File: tb/tb_aes_prng_ctrl.sv
// Directed bench: dut_a uses a reseed period of 3, dut_b disables forced reseed with a 2-bit counter to reach saturation.
module tb_aes_prng_ctrl;

   logic        clk = 1'b0;
   logic        nrst;
   logic [79:0] seed_in;
   logic        seed_valid, req_valid, aes_ready, aes_cipher_valid, prng_busy, prng_out_valid;

   logic        seed_ready_a, req_ready_a, aes_valid_in_a, prng_start_reseed_a, prng_out_ready_a;
   logic        need_reseed_a, rnd_starve_a;
   logic [79:0] prng_seed_a;
   logic [15:0] enc_count_a;

   logic        seed_ready_b, req_ready_b, aes_valid_in_b, prng_start_reseed_b, prng_out_ready_b;
   logic        need_reseed_b, rnd_starve_b;
   logic [79:0] prng_seed_b;
   logic [1:0]  enc_count_b;

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [79:0] SEED1 = 80'h0123456789ABCDEF0011;
   localparam logic [79:0] SEED2 = 80'hFEDCBA9876543210ABCD;

   always #5 clk = ~clk;

   aes_prng_ctrl #(.RESEED_PERIOD(3), .CNT_W(16)) dut_a (
      .clk(clk), .nrst(nrst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(seed_ready_a),
      .req_valid(req_valid), .req_ready(req_ready_a), .aes_valid_in(aes_valid_in_a),
      .aes_ready(aes_ready), .aes_cipher_valid(aes_cipher_valid), .prng_seed(prng_seed_a),
      .prng_start_reseed(prng_start_reseed_a), .prng_busy(prng_busy), .prng_out_valid(prng_out_valid),
      .prng_out_ready(prng_out_ready_a), .need_reseed(need_reseed_a), .rnd_starve(rnd_starve_a),
      .enc_count(enc_count_a)
   );

   aes_prng_ctrl #(.RESEED_PERIOD(0), .CNT_W(2)) dut_b (
      .clk(clk), .nrst(nrst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(seed_ready_b),
      .req_valid(req_valid), .req_ready(req_ready_b), .aes_valid_in(aes_valid_in_b),
      .aes_ready(aes_ready), .aes_cipher_valid(aes_cipher_valid), .prng_seed(prng_seed_b),
      .prng_start_reseed(prng_start_reseed_b), .prng_busy(prng_busy), .prng_out_valid(prng_out_valid),
      .prng_out_ready(prng_out_ready_b), .need_reseed(need_reseed_b), .rnd_starve(rnd_starve_b),
      .enc_count(enc_count_b)
   );

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      nrst = 1'b0; seed_in = '0; seed_valid = 1'b0; req_valid = 1'b0;
      aes_ready = 1'b0; aes_cipher_valid = 1'b0; prng_busy = 1'b0; prng_out_valid = 1'b0;
      tick(); tick();
      chk("rst_need_reseed", need_reseed_a, 1);
      chk("rst_seed_ready", seed_ready_a, 1);
      chk("rst_req_ready", req_ready_a, 0);
      chk("rst_aes_valid_in", aes_valid_in_a, 0);
      chk("rst_out_ready", prng_out_ready_a, 0);
      chk("rst_start_reseed", prng_start_reseed_a, 0);
      chk("rst_prng_seed", prng_seed_a, 0);
      chk("rst_enc_count", enc_count_a, 0);
      chk("rst_rnd_starve", rnd_starve_a, 0);
      nrst = 1'b1;
      tick();

      // Initial seed.
      seed_in = SEED1; seed_valid = 1'b1; settle();
      chk("seed_ready_noseed", seed_ready_a, 1);
      tick();
      seed_valid = 1'b0; prng_busy = 1'b1; settle();
      chk("pulse_start", prng_start_reseed_a, 1);
      chk("pulse_seed", prng_seed_a, SEED1);
      chk("pulse_seed_ready", seed_ready_a, 0);
      chk("pulse_need_reseed", need_reseed_a, 0);
      tick();
      chk("wait_start_low", prng_start_reseed_a, 0);
      prng_out_valid = 1'b1;
      repeat (48) tick();
      chk("wait_busy_holds", seed_ready_a, 0);
      chk("wait_seed_held", prng_seed_a, SEED1);
      tick();
      prng_busy = 1'b0; settle();
      chk("wait_last_cycle", seed_ready_a, 0);
      tick();
      chk("ready_entered", seed_ready_a, 1);
      chk("ready_noaes_req_ready", req_ready_a, 0);
      chk("ready_enc_count0", enc_count_a, 0);
      aes_ready = 1'b1; settle();
      chk("ready_req_ready", req_ready_a, 1);

      // Encryption 1: request held across the accept.
      req_valid = 1'b1; settle();
      chk("enc1_aes_valid_in", aes_valid_in_a, 1);
      chk("enc1_out_ready_accept", prng_out_ready_a, 1);
      tick();
      chk("enc1_aes_valid_pulse", aes_valid_in_a, 0);
      chk("enc1_run_out_ready", prng_out_ready_a, 1);
      chk("enc1_run_req_ready", req_ready_a, 0);
      req_valid = 1'b0;
      repeat (20) tick();
      aes_cipher_valid = 1'b1;
      tick();
      aes_cipher_valid = 1'b0; settle();
      chk("enc1_count", enc_count_a, 1);
      chk("enc1_back_ready", req_ready_a, 1);
      chk("enc1_out_ready_idle", prng_out_ready_a, 0);
      chk("enc1_no_starve", rnd_starve_a, 0);

      // Encryption 2 with a one-cycle starvation.
      req_valid = 1'b1; tick();
      req_valid = 1'b0; tick();
      prng_out_valid = 1'b0; tick();
      prng_out_valid = 1'b1; settle();
      chk("enc2_starve_set", rnd_starve_a, 1);
      repeat (3) tick();
      aes_cipher_valid = 1'b1; tick();
      aes_cipher_valid = 1'b0; settle();
      chk("enc2_count", enc_count_a, 2);
      chk("enc2_starve_sticky", rnd_starve_a, 1);
      chk("enc2_need_reseed", need_reseed_a, 0);

      // Encryption 3 hits the reseed period.
      req_valid = 1'b1; tick();
      req_valid = 1'b0; repeat (4) tick();
      aes_cipher_valid = 1'b1; tick();
      aes_cipher_valid = 1'b0; settle();
      chk("enc3_count", enc_count_a, 3);
      chk("enc3_need_reseed", need_reseed_a, 1);
      chk("enc3_req_ready", req_ready_a, 0);
      chk("enc3_b_count", enc_count_b, 3);
      chk("enc3_b_need_reseed", need_reseed_b, 0);

      // Encryption 4: dut_a ignores it, dut_b saturates.
      req_valid = 1'b1; settle();
      chk("enc4_a_ignored", aes_valid_in_a, 0);
      chk("enc4_b_accept", aes_valid_in_b, 1);
      tick();
      req_valid = 1'b0; aes_cipher_valid = 1'b1; tick();
      aes_cipher_valid = 1'b0; settle();
      chk("enc4_a_count_held", enc_count_a, 3);
      chk("enc4_a_still_noseed", need_reseed_a, 1);
      chk("enc4_b_saturated", enc_count_b, 3);
      chk("enc4_b_back_ready", req_ready_b, 1);

      // Seed and request together: dut_b is in READY, the seed must win.
      seed_in = SEED2; seed_valid = 1'b1; req_valid = 1'b1; settle();
      chk("simul_b_seed_ready", seed_ready_b, 1);
      chk("simul_b_req_ready", req_ready_b, 0);
      chk("simul_b_aes_valid_in", aes_valid_in_b, 0);
      tick();
      seed_valid = 1'b0; req_valid = 1'b0; settle();
      chk("simul_b_pulse", prng_start_reseed_b, 1);
      chk("simul_a_pulse", prng_start_reseed_a, 1);
      chk("reseed_a_seed", prng_seed_a, SEED2);
      tick();
      chk("reseed_a_starve_until_done", rnd_starve_a, 1);
      tick();
      chk("reseed_a_starve_cleared", rnd_starve_a, 0);
      chk("reseed_a_count_cleared", enc_count_a, 0);
      chk("reseed_a_ready", req_ready_a, 1);
      chk("reseed_b_count_cleared", enc_count_b, 0);

      // Reset in the middle of a starved run.
      req_valid = 1'b1; tick();
      req_valid = 1'b0; prng_out_valid = 1'b0; tick();
      prng_out_valid = 1'b1; settle();
      chk("midrun_out_ready", prng_out_ready_a, 1);
      chk("midrun_starve", rnd_starve_a, 1);
      nrst = 1'b0; settle();
      chk("midrst_out_ready", prng_out_ready_a, 0);
      chk("midrst_need_reseed", need_reseed_a, 1);
      chk("midrst_seed_ready", seed_ready_a, 1);
      chk("midrst_starve", rnd_starve_a, 0);
      chk("midrst_prng_seed", prng_seed_a, 0);
      chk("midrst_req_ready", req_ready_a, 0);
      aes_cipher_valid = 1'b1; tick();
      aes_cipher_valid = 1'b0; nrst = 1'b1; tick();
      chk("midrst_no_count", enc_count_a, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
